// File: rtl/kplic_pkg.sv
// Shared KPLIC definitions: gateway channel state encodings and interrupt type encodings.
package kplic_pkg;

    typedef enum logic [1:0] {
        KPLIC_GW_IDLE = 2'd0,
        KPLIC_GW_PEND = 2'd1,
        KPLIC_GW_BUSY = 2'd2
    } kplic_gw_state_e;

    localparam logic KPLIC_INT_EDGE  = 1'b1;
    localparam logic KPLIC_INT_LEVEL = 1'b0;

endpackage

// File: rtl/kplic_gateway_ch.sv
// One KPLIC gateway channel: optional synchroniser, rising-edge detect,
// saturating pending-edge counter with sticky overflow, request FSM.
// Build option: KPLIC_GW_SYNC_EN adds a two-flop synchroniser on external_int.
module kplic_gateway_ch
    import kplic_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             kplic_clk,
    input  logic             kplic_rstn,
    input  logic             external_int,
    input  logic             int_enable,
    input  logic             int_type,
    input  logic             int_claim,
    input  logic             int_completion,
    input  logic             int_ovf_clr,
    output logic             valid_int_req,
    output logic             int_overflow,
    output logic [CNT_W-1:0] int_pending_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            int_s;
    logic            int_s_d;
    logic            rise;
    logic            is_edge;
    logic            claim_ok;
    logic            ovf_event;
    logic            req_cond;
    logic [CNT_W-1:0] cnt_q;
    logic            ovf_q;
    logic            valid_q;
    kplic_gw_state_e state_q, state_d;

`ifdef KPLIC_GW_SYNC_EN
    logic sync_q1, sync_q2;

    // Two-flop synchroniser for the asynchronous source.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= external_int;
            sync_q2 <= sync_q1;
        end
    end

    assign int_s = sync_q2;
`else
    assign int_s = external_int;
`endif

    // Delayed copy of the synchronised source for edge detection.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) int_s_d <= 1'b0;
        else             int_s_d <= int_s;
    end

    assign rise      = int_s & ~int_s_d;
    assign is_edge   = (int_type == KPLIC_INT_EDGE);
    assign claim_ok  = (state_q == KPLIC_GW_PEND) & int_claim;
    assign ovf_event = rise & ~claim_ok & (cnt_q == CNT_MAX);
    assign req_cond  = int_enable & (is_edge ? ((cnt_q != '0) | rise) : int_s);

    // Pending-edge counter and sticky overflow; both held at zero in level mode.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (!is_edge) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (rise && !claim_ok) begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            end else if (!rise && claim_ok && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (ovf_event)        ovf_q <= 1'b1;
            else if (int_ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Request state register plus registered request output.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            state_q <= KPLIC_GW_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == KPLIC_GW_PEND);
        end
    end

    // Next-state logic for the request handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KPLIC_GW_IDLE: if (req_cond) state_d = KPLIC_GW_PEND;
            KPLIC_GW_PEND: begin
                if (int_claim)                 state_d = KPLIC_GW_BUSY;
                else if (!int_enable)          state_d = KPLIC_GW_IDLE;
                else if (!is_edge && !int_s)   state_d = KPLIC_GW_IDLE;
            end
            KPLIC_GW_BUSY: if (int_completion) state_d = KPLIC_GW_IDLE;
            default:                           state_d = KPLIC_GW_IDLE;
        endcase
    end

    assign valid_int_req   = valid_q;
    assign int_overflow    = ovf_q;
    assign int_pending_cnt = cnt_q;

endmodule

// File: rtl/kplic_gateway_array.sv
// Array of KPLIC gateway channels, one per external interrupt source.
// Build option: KPLIC_GW_SYNC_EN (see kplic_gateway_ch) selects synchronised inputs.
module kplic_gateway_array
    import kplic_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                     kplic_clk,
    input  logic                     kplic_rstn,
    input  logic [NUM_SRC-1:0]       external_int,
    input  logic [NUM_SRC-1:0]       int_enable,
    input  logic [NUM_SRC-1:0]       int_type,
    input  logic [NUM_SRC-1:0]       int_claim,
    input  logic [NUM_SRC-1:0]       int_completion,
    input  logic [NUM_SRC-1:0]       int_ovf_clr,
    output logic [NUM_SRC-1:0]       valid_int_req,
    output logic [NUM_SRC-1:0]       int_overflow,
    output logic [NUM_SRC*CNT_W-1:0] int_pending_cnt
);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
        kplic_gateway_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .kplic_clk      (kplic_clk),
            .kplic_rstn     (kplic_rstn),
            .external_int   (external_int[i]),
            .int_enable     (int_enable[i]),
            .int_type       (int_type[i]),
            .int_claim      (int_claim[i]),
            .int_completion (int_completion[i]),
            .int_ovf_clr    (int_ovf_clr[i]),
            .valid_int_req  (valid_int_req[i]),
            .int_overflow   (int_overflow[i]),
            .int_pending_cnt(int_pending_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_kplic_gateway_array.sv
// Randomised scoreboard bench for kplic_gateway_array with a per-channel reference model.
module tb_kplic_gateway_array;

    localparam int NS   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef KPLIC_GW_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic             kplic_clk = 1'b0;
    logic             kplic_rstn = 1'b0;
    logic [NS-1:0]    external_int = '0;
    logic [NS-1:0]    int_enable = '0;
    logic [NS-1:0]    int_type = '0;
    logic [NS-1:0]    int_claim = '0;
    logic [NS-1:0]    int_completion = '0;
    logic [NS-1:0]    int_ovf_clr = '0;
    logic [NS-1:0]    valid_int_req;
    logic [NS-1:0]    int_overflow;
    logic [NS*CW-1:0] int_pending_cnt;

    kplic_gateway_array #(
        .NUM_SRC(NS),
        .CNT_W  (CW)
    ) dut (
        .kplic_clk      (kplic_clk),
        .kplic_rstn     (kplic_rstn),
        .external_int   (external_int),
        .int_enable     (int_enable),
        .int_type       (int_type),
        .int_claim      (int_claim),
        .int_completion (int_completion),
        .int_ovf_clr    (int_ovf_clr),
        .valid_int_req  (valid_int_req),
        .int_overflow   (int_overflow),
        .int_pending_cnt(int_pending_cnt)
    );

    always #5 kplic_clk = ~kplic_clk;

    typedef struct {
        logic [NS-1:0]    req;
        logic [NS-1:0]    ovf;
        logic [NS*CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: per channel, pending edges as a plain integer and the
    // handshake as two flags (asking = request shown, serving = claimed).
    int m_cnt[NS];
    bit m_ask[NS], m_svc[NS], m_ovf[NS], m_prev[NS], m_y1[NS], m_y2[NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_cnt[i] = 0; m_ask[i] = 0; m_svc[i] = 0; m_ovf[i] = 0;
            m_prev[i] = 0; m_y1[i] = 0; m_y2[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NS; i++) begin
            bit s, rise, took, want;
            int n;
            s    = SYNC ? m_y2[i] : external_int[i];
            rise = s && !m_prev[i];
            took = m_ask[i] && int_claim[i];
            want = int_enable[i] && (int_type[i] ? (m_cnt[i] > 0 || rise) : s);
            if (int_type[i]) begin
                n = m_cnt[i] + int'(rise) - int'(took);
                if (n > CMAX) begin
                    n = CMAX;
                    m_ovf[i] = 1;
                end else if (int_ovf_clr[i]) begin
                    m_ovf[i] = 0;
                end
                if (n < 0) n = 0;
                m_cnt[i] = n;
            end else begin
                m_cnt[i] = 0;
                m_ovf[i] = 0;
            end
            if (m_ask[i]) begin
                if (took) begin
                    m_ask[i] = 0; m_svc[i] = 1;
                end else if (!int_enable[i] || (!int_type[i] && !s)) begin
                    m_ask[i] = 0;
                end
            end else if (m_svc[i]) begin
                if (int_completion[i]) m_svc[i] = 0;
            end else if (want) begin
                m_ask[i] = 1;
            end
            m_prev[i] = s;
            m_y2[i]   = m_y1[i];
            m_y1[i]   = external_int[i];
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req = '0; e.ovf = '0; e.cnt = '0;
        for (int i = 0; i < NS; i++) begin
            e.req[i]           = m_ask[i];
            e.ovf[i]           = m_ovf[i];
            e.cnt[i*CW +: CW]  = CW'(m_cnt[i]);
        end
        return e;
    endfunction

    function automatic logic [NS-1:0] rbits(input int pct);
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = ($urandom_range(99) < pct);
        return v;
    endfunction

    // One stimulus cycle: drive at negedge, advance the model, queue the expectation.
    task automatic cycle(input int tog, input int clm, input int cmp, input int clr, input int en);
        @(negedge kplic_clk);
        external_int   = external_int ^ rbits(tog);
        int_claim      = rbits(clm);
        int_completion = rbits(cmp);
        int_ovf_clr    = rbits(clr);
        int_enable     = rbits(en);
        if (!kplic_rstn) model_reset();
        else             model_step();
        sb_q.push_back(model_out());
    endtask

    // Monitor: compares the DUT against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge kplic_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("valid_int_req",   64'(valid_int_req),   64'(e.req));
                check("int_overflow",    64'(int_overflow),    64'(e.ovf));
                check("int_pending_cnt", 64'(int_pending_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        model_reset();
        int_type = 8'b1111_1100;
        repeat (3) cycle(0, 0, 0, 0, 100);
        @(negedge kplic_clk);
        kplic_rstn = 1'b1;
        model_step();
        sb_q.push_back(model_out());

        // Rare claims: counters saturate and overflow flags set.
        repeat (600) cycle(30, 10, 10, 3, 95);
        // Busy handshakes drain the counters.
        repeat (600) cycle(20, 50, 50, 5, 95);

        // Asynchronous reset in the middle of a cycle.
        @(negedge kplic_clk);
        #2;
        kplic_rstn = 1'b0;
        #1;
        check("async_rst_req", 64'(valid_int_req),   64'(0));
        check("async_rst_ovf", 64'(int_overflow),    64'(0));
        check("async_rst_cnt", 64'(int_pending_cnt), 64'(0));
        model_reset();
        int_type = rbits(60);
        repeat (2) cycle(20, 20, 20, 0, 80);
        @(negedge kplic_clk);
        kplic_rstn = 1'b1;
        model_step();
        sb_q.push_back(model_out());

        repeat (800) cycle(25, 25, 25, 5, 70);
        repeat (200) cycle(40, 5, 30, 10, 90);

        // Drain the scoreboard within a bounded number of edges.
        repeat (3) @(posedge kplic_clk);
        #2;
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kplic_gateway_array.md
# kplic_gateway_array

Parametrised array of KPLIC interrupt gateways, one channel per external source, sitting between the system interrupt inputs and kplic_core. Each channel synchronises its source and detects true rising edges. Edge-triggered channels count pending edges in a saturating counter with a sticky overflow flag. Each channel presents a registered request held until the core claims it, then blocks further requests until software completion.

## Interface
Parameters:
- NUM_SRC, 8: number of gateway channels (1..64)
- CNT_W, 4: pending-edge counter width per channel (1..8); saturates at 2^CNT_W-1

Ports:
- kplic_clk  input  1  kplic clock
- kplic_rstn  input  1  kplic reset; asynchronous, active-low
- external_int  input  NUM_SRC  raw interrupt sources, bit i = channel i
- int_enable  input  NUM_SRC  per-channel enable, 1=enabled
- int_type  input  NUM_SRC  1=edge-triggered, 0=level-sensitive
- int_claim  input  NUM_SRC  one-cycle claim pulse from kplic_core
- int_completion  input  NUM_SRC  one-cycle completion pulse from kplic_reg
- int_ovf_clr  input  NUM_SRC  one-cycle clear of the sticky overflow flag
- valid_int_req  output  NUM_SRC  registered request to kplic_core
- int_overflow  output  NUM_SRC  sticky flag: an edge was lost at saturation
- int_pending_cnt  output  NUM_SRC*CNT_W  per-channel pending count; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Per channel, int_s is the synchronised source, and int_s_d is int_s delayed one cycle.
- A rising edge is int_s & ~int_s_d.
- Channel states:
  - IDLE=0: no request outstanding.
  - PEND=1: request presented, valid_int_req=1.
  - BUSY=2: claimed, awaiting completion.
- req_cond: int_enable & (int_type ? (cnt!=0 | edge) : int_s).
- IDLE -> PEND when req_cond.
- PEND -> BUSY on int_claim.
- PEND -> IDLE without claim when int_enable=0. In level mode it also returns to IDLE when int_s=0. The edge count is retained in both cases.
- BUSY -> IDLE on int_completion.
- int_claim in IDLE/BUSY is ignored. int_completion in IDLE/PEND is ignored.
- valid_int_req = (state==PEND).
- Edge-mode counter:
  - Increments on edge, counted regardless of int_enable or state.
  - Decrements on an accepted claim (PEND & int_claim).
  - Edge and accepted claim in the same cycle: count unchanged.
  - Edge at cnt==2^CNT_W-1 with no accepted claim: count holds and int_overflow sets.
  - The count never wraps.
- Level mode (int_type=0): counter forced to 0 each cycle and int_overflow forced to 0. Changing int_type while not IDLE is a software error; the state machine is unaffected.
- int_ovf_clr clears int_overflow. A simultaneous new overflow event wins, so the flag stays 1.

## Timing
- Reset: all state IDLE; valid_int_req, int_overflow, int_pending_cnt, sync flops and int_s_d all 0.
- Reset mid-operation discards all pending counts and requests immediately.
- With sync enabled, external_int rising before clock edge k:
  - int_s=1 after edge k+1.
  - valid_int_req=1 after edge k+2, i.e. 3 edges of latency.
- Claim at edge m: valid_int_req=0 and count decremented after edge m.
- Completion at edge n plus req_cond still true: valid_int_req=1 again after edge n+1. The IDLE state lasts one cycle minimum.
- All outputs are registered; there are no combinational paths from any input to any output.

## Configuration
- KPLIC_GW_SYNC_EN defined: two-flop synchroniser on each external_int bit. Latency is as stated in Timing.
- KPLIC_GW_SYNC_EN undefined: int_s = external_int directly, for sources already in the kplic_clk domain. Latency is 1 edge from input to valid_int_req.

## Structure
- Shared kplic_pkg (alongside kplic_defines.vh) holds:
  - the state encodings KPLIC_GW_IDLE/PEND/BUSY;
  - the type encodings KPLIC_INT_EDGE=1, KPLIC_INT_LEVEL=0.
- Sub-module kplic_gateway_ch:
  - implements one channel: sync, edge detect, counter, overflow, FSM.
  - takes parameter CNT_W.
- The top level uses a generate loop over NUM_SRC and packs int_pending_cnt.

## Test plan
- Level channel 0, enable=1, external_int[0] rises → valid_int_req[0]=1 on the 3rd edge. Claim → 0. external_int held, completion → valid_int_req[0]=1 two edges later.
- Level channel 1: external_int drops while PEND and unclaimed → valid_int_req[1] returns to 0 by the 3rd edge after the drop. No completion is needed.
- Edge channel 2:
  - 3 pulses while BUSY → int_pending_cnt=3.
  - Completion → valid_int_req re-asserts.
  - Three claim/complete rounds → cnt reaches 0 and the request stays 0.
- CNT_W=2, edge channel 3: 5 edges with no claim → cnt=3, int_overflow=1. int_ovf_clr → 0 while cnt stays 3.
- Edge channel 4: new edge and accepted claim in the same cycle with cnt=1 → cnt stays 1, state BUSY.
- Reset asserted mid-BUSY with cnt=2 → all outputs 0 asynchronously. After release, no request without a new edge.
